// File: rtl/ip_chk_pkg.sv
// Shared types and constants for the IPv4 header checksum checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: verdict encodings, walker state enum, checksum lane geometry and
// the version/IHL byte that identifies an option-less IPv4 header.
package ip_chk_pkg;

  localparam int CSUM_W     = 16;  // ones'-complement word width
  localparam int CSUM_LANES = 4;   // 16-bit words per 64-bit beat

  localparam logic [7:0]        IPV4_VER_IHL = 8'h45;
  localparam logic [CSUM_W-1:0] CSUM_GOOD    = 16'hFFFF;

  typedef enum logic [1:0] {
    CHK_OK       = 2'd0,
    CHK_BAD_CSUM = 2'd1,
    CHK_NOT_V4   = 2'd2,
    CHK_RUNT     = 2'd3
  } chk_status_t;

  typedef enum logic [2:0] {
    S_PRE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_BODY
  } state_t;

endpackage

// File: rtl/ip_csum_acc4.sv
// Adds up to four 16-bit words into a 16-bit ones'-complement accumulator.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is committed.
//
// Ports:
//   acc_i   running folded sum
//   word_i  four candidate words, lane 3 = most significant 16 bits of a beat
//   en_i    per-lane enable; disabled lanes contribute zero
//   sum_o   double-folded 16-bit ones'-complement sum
module ip_csum_acc4
  import ip_chk_pkg::*;
(
  input  logic [CSUM_W-1:0]                 acc_i,
  input  logic [CSUM_LANES-1:0][CSUM_W-1:0] word_i,
  input  logic [CSUM_LANES-1:0]             en_i,
  output logic [CSUM_W-1:0]                 sum_o
);

  // Five 16-bit operands fit in 19 bits.
  logic [CSUM_W+2:0] raw;
  logic [CSUM_W:0]   t;

  always_comb begin
    raw = {3'b000, acc_i};
    for (int k = 0; k < CSUM_LANES; k++) begin
      if (en_i[k]) begin
        raw = raw + {3'b000, word_i[k]};
      end
    end
    // First fold can itself carry out of bit 15; the second fold absorbs
    // that single carry and cannot overflow again.
    t     = {1'b0, raw[CSUM_W-1:0]} + {{(CSUM_W-2){1'b0}}, raw[CSUM_W+2:CSUM_W]};
    sum_o = t[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, t[CSUM_W]};
  end

endmodule

// File: rtl/ip_hdr_checksum_check.sv
// Verifies the IPv4 header checksum of each packet flowing past on a 64-bit stream.
// Latency: data 0 cycles (wire pass-through); verdict strobe 1 cycle after the tlast beat.
// Backpressure: none added; i_tready is o_tready, all state holds while no beat occurs.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   i_tdata/i_tlast/i_tvalid      upstream stream (big-endian, byte 0 in [63:56])
//   i_tready                      copy of o_tready
//   o_tdata/o_tlast/o_tvalid      combinational copies of the upstream stream
//   o_tready                      downstream ready
//   o_chk_valid/o_chk_status      one-cycle verdict strobe and its chk_status_t code
//   o_cnt_ok/o_cnt_bad            OK / BAD_CSUM packet counters
// Build option: define IP_HDR_CHECK_CNT_EN to implement the counters; otherwise
// both counter ports read 0.
module ip_hdr_checksum_check
  import ip_chk_pkg::*;
#(
  parameter int unsigned IP_WORD_OFFSET = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        o_chk_valid,
  output logic [1:0]  o_chk_status,
  output logic [31:0] o_cnt_ok,
  output logic [31:0] o_cnt_bad
);

  // With no preamble words the walker idles directly on the first header word.
  localparam state_t START_STATE = (IP_WORD_OFFSET == 0) ? S_HDR0 : S_PRE;

  // Pass-through path.
  assign o_tdata  = i_tdata;
  assign o_tlast  = i_tlast;
  assign o_tvalid = i_tvalid;
  assign i_tready = o_tready;

  logic beat;
  assign beat = i_tvalid & o_tready;

  state_t                   state_q;
  logic [7:0]               pre_cnt_q;
  logic [CSUM_W-1:0]        acc_q;
  logic                     ver_ihl_ok_q;
  logic                     chk_vld_q;
  chk_status_t              chk_status_q;

  logic [CSUM_LANES-1:0][CSUM_W-1:0] lane_word;
  logic [CSUM_LANES-1:0]             lane_en;
  logic [CSUM_W-1:0]                 acc_d;
  chk_status_t                       verdict;

  assign lane_word = i_tdata;

  ip_csum_acc4 u_acc (
    .acc_i  (acc_q),
    .word_i (lane_word),
    .en_i   (lane_en),
    .sum_o  (acc_d)
  );

  // Lane selection and verdict for the current beat. In S_BODY no lane is
  // enabled, so acc_d equals acc_q and one compare serves S_HDR2 and S_BODY.
  always_comb begin
    lane_en = '0;
    verdict = CHK_RUNT;
    case (state_q)
      S_HDR0, S_HDR1: lane_en = 4'b1111;
      S_HDR2:         lane_en = 4'b1100;  // bytes 16-19; low half is payload
      default:        lane_en = '0;
    endcase
    if (state_q == S_HDR2 || state_q == S_BODY) begin
      if (!ver_ihl_ok_q) begin
        verdict = CHK_NOT_V4;
      end else if (acc_d == CSUM_GOOD) begin
        verdict = CHK_OK;
      end else begin
        verdict = CHK_BAD_CSUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= START_STATE;
      pre_cnt_q    <= '0;
      acc_q        <= '0;
      ver_ihl_ok_q <= 1'b0;
      chk_vld_q    <= 1'b0;
      chk_status_q <= CHK_OK;
    end else begin
      chk_vld_q <= beat & i_tlast;
      if (beat && i_tlast) begin
        chk_status_q <= verdict;
      end
      if (beat) begin
        if (i_tlast) begin
          state_q      <= START_STATE;
          pre_cnt_q    <= '0;
          acc_q        <= '0;
          ver_ihl_ok_q <= 1'b0;
        end else begin
          case (state_q)
            S_PRE: begin
              if (pre_cnt_q == 8'(IP_WORD_OFFSET - 1)) begin
                state_q   <= S_HDR0;
                pre_cnt_q <= '0;
              end else begin
                pre_cnt_q <= pre_cnt_q + 8'd1;
              end
            end
            S_HDR0: begin
              ver_ihl_ok_q <= (i_tdata[63:56] == IPV4_VER_IHL);
              acc_q        <= acc_d;
              state_q      <= S_HDR1;
            end
            S_HDR1: begin
              acc_q   <= acc_d;
              state_q <= S_HDR2;
            end
            S_HDR2: begin
              acc_q   <= acc_d;
              state_q <= S_BODY;
            end
            S_BODY:  state_q <= S_BODY;
            default: state_q <= START_STATE;
          endcase
        end
      end
    end
  end

  assign o_chk_valid  = chk_vld_q;
  assign o_chk_status = chk_status_q;

`ifdef IP_HDR_CHECK_CNT_EN
  logic [31:0] cnt_ok_q;
  logic [31:0] cnt_bad_q;

  // Counters advance on the same edge that raises the verdict strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_ok_q  <= '0;
      cnt_bad_q <= '0;
    end else if (beat && i_tlast) begin
      if (verdict == CHK_OK) begin
        cnt_ok_q <= cnt_ok_q + 32'd1;
      end
      if (verdict == CHK_BAD_CSUM) begin
        cnt_bad_q <= cnt_bad_q + 32'd1;
      end
    end
  end

  assign o_cnt_ok  = cnt_ok_q;
  assign o_cnt_bad = cnt_bad_q;
`else
  assign o_cnt_ok  = '0;
  assign o_cnt_bad = '0;
`endif

endmodule

// File: tb/tb_ip_hdr_checksum_check.sv
// Self-checking bench for ip_hdr_checksum_check: directed header cases plus
// randomized packets, gaps and stalls checked against a byte-level model.
// Counter expectations follow the IP_HDR_CHECK_CNT_EN build option.
module tb_ip_hdr_checksum_check;

  localparam int OFF     = 2;
  localparam int CLK_PER = 10;
`ifdef IP_HDR_CHECK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [63:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_chk_valid;
  logic [1:0]  o_chk_status;
  logic [31:0] o_cnt_ok;
  logic [31:0] o_cnt_bad;

  always #(CLK_PER/2) clk = ~clk;

  ip_hdr_checksum_check #(.IP_WORD_OFFSET(OFF)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_tdata      (i_tdata),
    .i_tlast      (i_tlast),
    .i_tvalid     (i_tvalid),
    .i_tready     (i_tready),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .o_chk_valid  (o_chk_valid),
    .o_chk_status (o_chk_status),
    .o_cnt_ok     (o_cnt_ok),
    .o_cnt_bad    (o_cnt_bad)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] pkt [16];
  int          pkt_len;
  logic [7:0]  hdr [20];
  int          exp_q[$];
  int unsigned mdl_ok  = 0;
  int unsigned mdl_bad = 0;

  // End-around-carry ones'-complement sum of the ten header words.
  function automatic logic [15:0] ocsum(input logic [7:0] a [20]);
    int unsigned s = 0;
    for (int k = 0; k < 10; k++) begin
      s = s + {16'h0, a[2*k], a[2*k+1]};
      if (s > 32'h0000_FFFF) s = s - 32'h0000_FFFF;
    end
    return 16'(s);
  endfunction

  // Status derived purely from the bytes of the packet as sent.
  function automatic int ref_status();
    logic [7:0] hb [20];
    int b;
    if (pkt_len < OFF + 3) return 3;
    for (int i = 0; i < 20; i++) begin
      b = OFF*8 + i;
      hb[i] = pkt[b/8][63-8*(b%8) -: 8];
    end
    if (hb[0] != 8'h45) return 2;
    return (ocsum(hb) == 16'hFFFF) ? 0 : 1;
  endfunction

  // Fill pkt with random bytes and overlay hdr at the IP offset.
  task automatic build_pkt(input int len);
    int b;
    pkt_len = len;
    for (int j = 0; j < 16; j++) pkt[j] = {$urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      b = OFF*8 + i;
      pkt[b/8][63-8*(b%8) -: 8] = hdr[i];
    end
  endtask

  task automatic load_hdr(input logic [159:0] h);
    for (int i = 0; i < 20; i++) hdr[i] = h[159-8*i -: 8];
  endtask

  task automatic rand_hdr(input bit force_good);
    logic [15:0] c;
    for (int i = 0; i < 20; i++) hdr[i] = 8'($urandom);
    hdr[0] = (force_good || $urandom_range(0, 99) < 85) ? 8'h45 : 8'($urandom);
    hdr[10] = 8'h00;
    hdr[11] = 8'h00;
    c = ~ocsum(hdr);
    hdr[10] = c[15:8];
    hdr[11] = c[7:0];
    if (!force_good && $urandom_range(0, 99) < 30)
      hdr[$urandom_range(0, 19)] ^= 8'($urandom_range(1, 255));
  endtask

  // ---------------- driver ----------------
  // Drives pkt[0..pkt_len-1]; gap_pct = idle-cycle probability, stall_beat = beat
  // index held off by o_tready low for 3 cycles (-1 none); abort = no tlast.
  task automatic send(input int gap_pct, input int stall_beat, input bit abort);
    int i = 0;
    int stalls = 0;
    if (!abort) exp_q.push_back(ref_status());
    while (i < pkt_len) begin
      i_tdata  = pkt[i];
      i_tlast  = !abort && (i == pkt_len - 1);
      i_tvalid = ($urandom_range(0, 99) >= gap_pct);
      o_tready = 1'b1;
      if (i == stall_beat && stalls < 3) begin
        o_tready = 1'b0;
        i_tvalid = 1'b1;
        stalls++;
      end
      @(posedge clk);
      if (i_tvalid && o_tready) i++;
      #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
  endtask

  task automatic pulse_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  bit pend = 1'b0;

  always @(negedge clk) begin
    int e;
    check("chk_valid", o_chk_valid, pend);
    if (pend && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("chk_status", o_chk_status, e);
      if (e == 0) mdl_ok++;
      if (e == 1) mdl_bad++;
      check("cnt_ok", o_cnt_ok, CNT_EN ? mdl_ok : 0);
      check("cnt_bad", o_cnt_bad, CNT_EN ? mdl_bad : 0);
    end
    if (i_tvalid) begin
      check("o_tdata", o_tdata, i_tdata);
      check("o_tlast", o_tlast, i_tlast);
    end
    check("o_tvalid", o_tvalid, i_tvalid);
    check("i_tready", i_tready, o_tready);
    if (!reset_n) begin
      mdl_ok  = 0;
      mdl_bad = 0;
    end
    pend = reset_n && i_tvalid && o_tready && i_tlast;
  end

  initial begin
    #(CLK_PER * 200000);
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  localparam logic [159:0] GOOD_HDR = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;

  initial begin
    reset_n  = 1'b0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_chk_valid", o_chk_valid, 0);
    check("rst_chk_status", o_chk_status, 0);
    check("rst_cnt_ok", o_cnt_ok, 0);
    check("rst_cnt_bad", o_cnt_bad, 0);
    @(posedge clk);
    #1;

    // Directed: good, bad checksum, wrong version/IHL, runt, tlast on HDR2 beat.
    load_hdr(GOOD_HDR);              build_pkt(6); send(0, -1, 0);
    load_hdr(GOOD_HDR); hdr[11] = 8'h62; build_pkt(6); send(0, -1, 0);
    load_hdr(GOOD_HDR); hdr[0] = 8'h46;  build_pkt(6); send(0, -1, 0);
    load_hdr(GOOD_HDR);              build_pkt(4); send(0, -1, 0);
    load_hdr(GOOD_HDR);              build_pkt(5); send(0, -1, 0);
    repeat (2) @(posedge clk);
    #1;

    // Gaps plus a 3-cycle downstream stall on the second header word.
    load_hdr(GOOD_HDR); build_pkt(6); send(30, 3, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset after 3 beats of a packet, then a fresh good packet.
    load_hdr(GOOD_HDR); build_pkt(3); send(0, -1, 1);
    pulse_reset(1);
    load_hdr(GOOD_HDR); build_pkt(6); send(0, -1, 0);

    // Back-to-back single-beat packets: a strobe on every cycle.
    for (int k = 0; k < 20; k++) begin
      build_pkt(1);
      send(0, -1, 0);
    end

    // Randomized lengths, headers, gaps and stalls.
    for (int k = 0; k < 300; k++) begin
      rand_hdr(1'b0);
      build_pkt($urandom_range(1, 9));
      send($urandom_range(0, 40), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1, 0);
    end
    repeat (3) @(posedge clk);
    #1;

    // 1000 back-to-back valid packets from a clean reset.
    pulse_reset(2);
    for (int k = 0; k < 1000; k++) begin
      rand_hdr(1'b1);
      build_pkt(6);
      send(0, -1, 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cnt_ok_1000", o_cnt_ok, CNT_EN ? 1000 : 0);
    check("cnt_bad_1000", o_cnt_bad, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
